// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: opcodes, FSM states and
// the active-low 7-segment glyphs (bit order g..a).
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_CONV = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode display driver with leading-zero blanking
// and an error glyph override on digit 0.
module seg7_scan
   import calc_pkg::*;
#(
   parameter int DIGITS      = 5,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   i_bcd,
   input  logic                  i_err,
   output logic [6:0]            o_seg,
   output logic [DIGITS-1:0]     o_an
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]     r_cnt;
   logic [IW-1:0]     r_idx;
   logic [DIGITS-1:0] w_upper_zero;
   logic [3:0]        w_digit;
   logic [6:0]        w_seg_next;
   logic [DIGITS-1:0] w_an_next;

   // w_upper_zero[i]: digit i and everything above it are zero
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_lz
         assign w_upper_zero[gi] = ~|i_bcd[4*DIGITS-1 : 4*gi];
      end
   endgenerate

   always_comb begin
      w_digit   = i_bcd[{r_idx, 2'b00} +: 4];
      w_an_next = ~(DIGITS'(1) << r_idx);
      if (i_err)
         w_seg_next = (r_idx == '0) ? SEG_E : SEG_BLANK;
      else if (r_idx != '0 && w_upper_zero[r_idx])
         w_seg_next = SEG_BLANK;
      else
         w_seg_next = bcd_to_seg(w_digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
         o_seg <= SEG_BLANK;
         o_an  <= '1;
      end else begin
         o_seg <= w_seg_next;
         o_an  <= w_an_next;
         if (r_cnt == CW'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle add/sub/mul/div calculator: shift-add multiply, restoring
// divide, double-dabble BCD conversion, scanned 7-segment output.
module seq_calculator
   import calc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 5,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 neg,
   output logic [2*WIDTH-1:0]   result,
   output logic [6:0]           seg,
   output logic [DIGITS-1:0]    an
);

   localparam int RW   = 2 * WIDTH;
   localparam int BW   = 4 * DIGITS;
   localparam int CNTW = $clog2(RW + 1);

   state_t           r_state, w_state_next;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b, r_rem;
   logic [RW-1:0]    r_acc, r_mcand, r_val, r_bin, r_result;
   logic [BW-1:0]    r_bcd, r_disp_bcd;
   logic [CNTW-1:0]  r_cnt;
   logic             r_err_pend, r_neg_pend, r_err, r_neg, r_done;

   logic [RW-1:0]    w_mul_acc, w_exec_val;
   logic [WIDTH:0]   w_rem_sh, w_trial;
   logic [WIDTH-1:0] w_div_quo, w_diff;
   logic [BW-1:0]    w_bcd_adj;
   logic             w_div0, w_exec_last;

   // r_a doubles as multiplier (shifted right) and dividend/quotient (shifted left)
   assign w_mul_acc = r_acc + (r_a[0] ? r_mcand : '0);
   assign w_rem_sh  = {r_rem, r_a[WIDTH-1]};
   assign w_trial   = w_rem_sh - {1'b0, r_b};
   assign w_div_quo = {r_a[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_diff    = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);
   assign w_div0    = (r_op == OP_DIV) && (r_b == '0);

   assign w_exec_last = (r_op == OP_ADD) || (r_op == OP_SUB) || w_div0 ||
                        (r_cnt == CNTW'(WIDTH - 1));

   always_comb begin
      case (r_op)
         OP_ADD:  w_exec_val = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
         OP_SUB:  w_exec_val = RW'(w_diff);
         OP_MUL:  w_exec_val = w_mul_acc;
         default: w_exec_val = w_div0 ? '0 : RW'(w_div_quo);
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_dabble
         assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                       r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_next = S_EXEC;
         S_EXEC: if (w_exec_last) w_state_next = w_div0 ? S_FIN : S_CONV;
         S_CONV: if (r_cnt == CNTW'(RW - 1)) w_state_next = S_FIN;
         S_FIN:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_EXEC) || (r_state == S_CONV);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= OP_ADD;
         r_a        <= '0;
         r_b        <= '0;
         r_rem      <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_val      <= '0;
         r_bin      <= '0;
         r_result   <= '0;
         r_bcd      <= '0;
         r_disp_bcd <= '0;
         r_cnt      <= '0;
         r_err_pend <= 1'b0;
         r_neg_pend <= 1'b0;
         r_err      <= 1'b0;
         r_neg      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_cnt  <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
         case (r_state)
            S_IDLE: if (start) begin
               r_op    <= op;
               r_a     <= a;
               r_b     <= b;
               r_rem   <= '0;
               r_acc   <= '0;
               r_mcand <= RW'(b);
               r_bcd   <= '0;
               r_err   <= 1'b0;
               r_neg   <= 1'b0;
            end
            S_EXEC: begin
               if (r_op == OP_MUL) begin
                  r_acc   <= w_mul_acc;
                  r_mcand <= r_mcand << 1;
                  r_a     <= r_a >> 1;
               end else if (r_op == OP_DIV) begin
                  r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                  r_a   <= w_div_quo;
               end
               if (w_exec_last) begin
                  r_val      <= w_exec_val;
                  r_bin      <= w_exec_val;
                  r_err_pend <= w_div0;
                  r_neg_pend <= (r_op == OP_SUB) && (r_a < r_b);
               end
            end
            S_CONV: {r_bcd, r_bin} <= {w_bcd_adj[BW-2:0], r_bin, 1'b0};
            S_FIN: begin
               r_result   <= r_val;
               r_disp_bcd <= r_bcd;
               r_err      <= r_err_pend;
               r_neg      <= r_neg_pend;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign done   = r_done;
   assign err    = r_err;
   assign neg    = r_neg;
   assign result = r_result;

   seg7_scan #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV)
   ) u_scan (
      .clk   (clk),
      .rst_n (rst_n),
      .i_bcd (r_disp_bcd),
      .i_err (r_err),
      .o_seg (seg),
      .o_an  (an)
   );

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator: directed vector table, random ops
// against an arithmetic reference model, and hand-written corner sequences.
module tb_seq_calculator;

   localparam int WIDTH       = 8;
   localparam int DIGITS      = 5;
   localparam int REFRESH_DIV = 4;
   localparam int RW          = 2 * WIDTH;

   localparam logic [6:0] T_BLANK = 7'b1111111;
   localparam logic [6:0] T_E     = 7'b0000110;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        op = 2'b00;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              busy, done, err, neg;
   logic [RW-1:0]     result;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   int total = 0;
   int bad   = 0;

   logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   typedef struct {
      logic [1:0] o;
      int         x;
      int         y;
      int         res;
      bit         ng;
      bit         er;
      int         lat;
   } vec_t;

   vec_t vecs[6];

   seq_calculator #(
      .WIDTH       (WIDTH),
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .neg    (neg),
      .result (result),
      .seg    (seg),
      .an     (an)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, act, exp);
      end
   endtask

   function automatic int p10(input int n);
      int v;
      v = 1;
      for (int i = 0; i < n; i++) v = v * 10;
      return v;
   endfunction

   // Reference model: plain arithmetic straight from the operation definitions
   function automatic int model_result(input logic [1:0] o, input int x, input int y);
      case (o)
         2'd0:    return x + y;
         2'd1:    return (x >= y) ? x - y : y - x;
         2'd2:    return x * y;
         default: return (y == 0) ? 0 : x / y;
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o, input int y);
      if (o == 2'd3 && y == 0) return 2;
      if (o < 2'd2)            return 2 + RW;
      return WIDTH + RW + 1;
   endfunction

   function automatic logic [6:0] model_seg(input int d, input int val, input bit e);
      if (e)                        return (d == 0) ? T_E : T_BLANK;
      if (d > 0 && val < p10(d))    return T_BLANK;
      return seg_lut[(val / p10(d)) % 10];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_display(input string tag, input int val, input bit e);
      logic [7:0] got [DIGITS];
      logic [DIGITS-1:0] sel;
      for (int d = 0; d < DIGITS; d++) got[d] = 8'hFF;
      repeat (2 * DIGITS * REFRESH_DIV) begin
         @(negedge clk);
         for (int d = 0; d < DIGITS; d++) begin
            sel = ~(DIGITS'(1) << d);
            if (an == sel) got[d] = {1'b0, seg};
         end
      end
      for (int d = 0; d < DIGITS; d++)
         chk($sformatf("%s_seg_digit%0d", tag, d), 32'(got[d]), 32'(model_seg(d, val, e)));
   endtask

   task automatic run_op(input logic [1:0] o, input int x, input int y, output int lat);
      @(negedge clk);
      op    = o;
      a     = WIDTH'(x);
      b     = WIDTH'(y);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("err_cleared_on_start", 32'(err), 32'd0);
      chk("neg_cleared_on_start", 32'(neg), 32'd0);
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_txn(input string tag, input logic [1:0] o, input int x, input int y,
                            input int e_res, input bit e_neg, input bit e_err, input int e_lat);
      int lat;
      run_op(o, x, y, lat);
      $display("txn %s op=%0d a=%0d b=%0d lat=%0d result=%0d neg=%0b err=%0b",
               tag, o, x, y, lat, result, neg, err);
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_result"}, 32'(result), 32'(e_res));
      chk({tag, "_neg"}, 32'(neg), 32'(e_neg));
      chk({tag, "_err"}, 32'(err), 32'(e_err));
      check_display(tag, e_res, e_err);
   endtask

   initial begin
      int dones;
      int n;
      logic [DIGITS-1:0] prev_an;
      logic [DIGITS-1:0] exp_an;
      logic [1:0] ro;
      int rx, ry;

      vecs[0] = '{2'd0, 200, 100,   300, 1'b0, 1'b0, 18};
      vecs[1] = '{2'd2, 255, 255, 65025, 1'b0, 1'b0, 25};
      vecs[2] = '{2'd1,   5,   9,     4, 1'b1, 1'b0, 18};
      vecs[3] = '{2'd3, 200,   7,    28, 1'b0, 1'b0, 25};
      vecs[4] = '{2'd3,   7,   0,     0, 1'b0, 1'b1,  2};
      vecs[5] = '{2'd0,  12,  34,    46, 1'b0, 1'b0, 18};

      // Asynchronous reset takes effect before any clock edge
      #2 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_an", 32'(an), 32'h1F);
      chk("rst_seg", 32'(seg), 32'h7F);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Anode walk: one digit at a time, REFRESH_DIV cycles each
      prev_an = an;
      for (int k = 0; k < 7; k++) begin
         n = 0;
         while (an == prev_an && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         exp_an = ~(DIGITS'(1) << (k % DIGITS));
         if (k > 0) chk("an_interval", 32'(n), 32'(REFRESH_DIV));
         chk("an_pattern", 32'(an), 32'(exp_an));
         prev_an = an;
      end
      check_display("idle", 0, 1'b0);

      for (int i = 0; i < 6; i++)
         check_txn($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y,
                   vecs[i].res, vecs[i].ng, vecs[i].er, vecs[i].lat);

      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         rx = int'($urandom_range(0, 255));
         ry = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
         check_txn($sformatf("rnd%0d", i), ro, rx, ry, model_result(ro, rx, ry),
                   (ro == 2'd1) && (rx < ry), (ro == 2'd3) && (ry == 0),
                   model_lat(ro, ry));
      end

      // A second start while a multiply is running must be ignored
      @(negedge clk);
      op = 2'd2; a = 8'd255; b = 8'd255; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      op = 2'd0; a = 8'd1; b = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      $display("txn ignored_start done_count=%0d result=%0d", dones, result);
      chk("ign_done_count", 32'(dones), 32'd1);
      chk("ign_result", 32'(result), 32'd65025);

      // Reset in the middle of conversion aborts without a done pulse
      @(negedge clk);
      op = 2'd0; a = 8'd200; b = 8'd100; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_an", 32'(an), 32'h1F);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      $display("txn mid_reset done_count=%0d result=%0d", dones, result);
      chk("midrst_no_done", 32'(dones), 32'd0);
      check_display("midrst", 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
